fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO, the successor to the fixed 8x32 FIFO.
- Generalised in WIDTH and DEPTH.
- Adds these over the previous generation: single-cycle simultaneous read+write, programmable almost_full/almost_empty thresholds, and a synchronous flush.
- Drop-in buffer between producer and consumer blocks in the same clock domain. Status and ack/error outputs are all registered.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of entries. Must be a power of two, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserts when data_count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when data_count ≤ AE_LEVEL.
- AW, log2(DEPTH), derived pointer width. Not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of contents; takes priority over rd_en/wr_en.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- d_in  in  WIDTH  write data.
- d_out  out  WIDTH  registered read data.
- data_count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  data_count==DEPTH.
- empty  out  1  data_count==0.
- almost_full  out  1  data_count ≥ AF_LEVEL.
- almost_empty  out  1  data_count ≤ AE_LEVEL.
- wr_ack  out  1  previous-edge write accepted.
- wr_err  out  1  previous-edge write rejected (full).
- rd_ack  out  1  previous-edge read accepted.
- rd_err  out  1  previous-edge read rejected (empty).

Behaviour:

Reset (reset_n=0 at a rising edge):
- head=0, tail=0, data_count=0, d_out=0, state=INIT.
- Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL≥1), all ack/err=0.
- Memory contents are don't-care.

Operation timing:
- Requests are sampled at rising edge N.
- Pointers, data_count, state and d_out all update at edge N.
- Flags, ack and err reflect the operation during cycle N→N+1. Read latency is 1 cycle.

Last-op FSM (3-bit state; acks/errs decode directly from state):
- INIT: after reset/flush; all ack/err low.
- NO_OP: neither rd_en nor wr_en.
- WRITE: wr only, not full → wr_ack.
- READ: rd only, not empty → rd_ack.
- WR_RD: both asserted, not empty → wr_ack and rd_ack; data_count unchanged.
- WR_ERROR: wr only while full → wr_err.
- RD_ERROR: rd only while empty → rd_err.
- WR_RDERR: both asserted while empty → write accepted, read rejected; wr_ack and rd_err; count +1.

Write and read rules:
- Both asserted while full is legal: both succeed and the head entry is read out in the same edge; result state WR_RD.
- Accepted write: mem[tail]←d_in; tail←tail+1, wrapping mod DEPTH.
- Accepted read: d_out←mem[head]; head←head+1, wrapping mod DEPTH.
- No fall-through: data written at edge N is readable at edge N+1 or later.
- d_out holds its last value when no read is accepted, including on rd_err.
- Rejected operations leave pointers, count and memory untouched.

data_count arithmetic:
- +1 on an accepted write only.
- −1 on an accepted read only.
- Unchanged otherwise.
- Never exceeds DEPTH and never underflows.

flush=1 (with reset_n=1):
- head=tail=0, data_count=0, state=INIT.
- d_out holds its value; rd_en/wr_en are ignored that cycle.

Reset precedence and reset mid-operation:
- reset_n=0 overrides flush.
- Reset mid-stream discards all contents; the first write after reset lands at index 0.

Decomposition:
- Package/header fifo_param_pkg holds the 3-bit state encodings: INIT=000, NO_OP=001, WRITE=010, READ=011, WR_RD=100, WR_ERROR=101, RD_ERROR=110, WR_RDERR=111.
- One sub-module, fifo_param_mem: DEPTH x WIDTH register file with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr → rdata). Not reset.
- Next-state, address/count calculation and output decode stay in fifo_param.

Test Plan:
1. Reset then idle, WIDTH=32, DEPTH=8 → data_count=0, empty=1, almost_empty=1, full=0, d_out=0, all ack/err=0.
2. Write 0x11..0x88 (8 writes), then a 9th write 0x99 → wr_ack pulses 8 times, data_count steps 1..8; almost_full rises when data_count reaches 6; full=1; 9th write gives wr_err=1 and memory unchanged.
3. From full, 9 reads → d_out=0x11..0x88 in order, each valid one cycle after its rd_en edge; 9th read gives rd_err=1 and d_out stays 0x88; empty=1.
4. Empty FIFO, rd_en=wr_en=1, d_in=0xA5 → wr_ack=1, rd_err=1, data_count=1. Next cycle rd_en=wr_en=1, d_in=0x5A → d_out=0xA5, wr_ack=rd_ack=1, count stays 1.
5. Full FIFO, rd_en=wr_en=1 for 10 consecutive cycles → count stays 8, no errors, outputs in FIFO order across the pointer wrap.
6. 5 entries held, flush=1 with wr_en=1 → next cycle count=0, empty=1, state INIT (no ack/err), d_out unchanged. Then repeat with reset_n=0 and flush=1 together → reset values, d_out=0.

Source files
------------

// File: rtl/fifo_param_pkg.sv
// fifo_param_pkg
//   Shared definitions for the parametrised synchronous FIFO.
//   Holds the 3-bit last-operation state encodings. The ack/err outputs
//   of fifo_param are decoded directly from these values.
package fifo_param_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] INIT     = 3'b000;
    localparam logic [ST_W-1:0] NO_OP    = 3'b001;
    localparam logic [ST_W-1:0] WRITE    = 3'b010;
    localparam logic [ST_W-1:0] READ     = 3'b011;
    localparam logic [ST_W-1:0] WR_RD    = 3'b100;
    localparam logic [ST_W-1:0] WR_ERROR = 3'b101;
    localparam logic [ST_W-1:0] RD_ERROR = 3'b110;
    localparam logic [ST_W-1:0] WR_RDERR = 3'b111;

endpackage

// File: rtl/fifo_param_mem.sv
// fifo_param_mem
//   DEPTH x WIDTH register file used as FIFO storage. The contents are not reset.
//   Ports:
//     clk   - rising-edge clock
//     we    - write enable; stores wdata at waddr on the clock edge
//     waddr - write address
//     wdata - write data
//     raddr - read address (combinational read port)
//     rdata - read data, mem[raddr]
module fifo_param_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param
//   Parametrised synchronous FIFO. It supports a read and a write in the
//   same cycle, programmable almost_full/almost_empty thresholds and a
//   synchronous flush.
//   Ports:
//     clk, reset_n        - rising-edge clock, synchronous active-low reset
//     flush               - synchronous clear; overrides rd_en/wr_en
//     wr_en, d_in         - write request and data
//     rd_en, d_out        - read request and registered read data (1-cycle latency)
//     data_count          - occupancy 0..DEPTH
//     full, empty         - registered occupancy flags
//     almost_full/_empty  - registered threshold flags (>= AF_LEVEL, <= AE_LEVEL)
//     wr_ack/wr_err       - the write at the previous edge was accepted/rejected
//     rd_ack/rd_err       - the read at the previous edge was accepted/rejected
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       d_in,
    output logic [WIDTH-1:0]       d_out,
    output logic [$clog2(DEPTH):0] data_count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   wr_ack,
    output logic                   wr_err,
    output logic                   rd_ack,
    output logic                   rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             is_full;
    logic             is_empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    fifo_param_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (tail),
        .wdata (d_in),
        .raddr (head),
        .rdata (mem_rdata)
    );

    // A write is also accepted while full if a read pops the head in the
    // same edge. The read port sees the old head entry before the write
    // lands, so tail==head causes no conflict.
    always_comb begin
        is_full  = (count == CNT_FULL);
        is_empty = (count == '0);
        rd_ok    = rd_en && !is_empty;
        wr_ok    = wr_en && (!is_full || rd_en);
        mem_we   = reset_n && !flush && wr_ok;

        state_nxt = NO_OP;
        case ({wr_en, rd_en})
            2'b10:   state_nxt = is_full  ? WR_ERROR : WRITE;
            2'b01:   state_nxt = is_empty ? RD_ERROR : READ;
            2'b11:   state_nxt = is_empty ? WR_RDERR : WR_RD;
            default: state_nxt = NO_OP;
        endcase

        count_nxt = count;
        if (!reset_n || flush) begin
            count_nxt = '0;
        end else if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            d_out <= '0;
            state <= INIT;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= INIT;
        end else begin
            if (wr_ok) begin
                tail <= tail + PTR_ONE;
            end
            if (rd_ok) begin
                head  <= head + PTR_ONE;
                d_out <= mem_rdata;
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // The flags are registered from the next count so that they line up
    // with data_count. count_nxt is already forced to zero on reset and flush.
    always_ff @(posedge clk) begin
        full         <= (count_nxt == CNT_FULL);
        empty        <= (count_nxt == '0);
        almost_full  <= (int'(count_nxt) >= AF_LEVEL);
        almost_empty <= (int'(count_nxt) <= AE_LEVEL);
    end

    assign data_count = count;
    assign wr_ack     = (state == WRITE) || (state == WR_RD) || (state == WR_RDERR);
    assign wr_err     = (state == WR_ERROR);
    assign rd_ack     = (state == READ) || (state == WR_RD);
    assign rd_err     = (state == RD_ERROR) || (state == WR_RDERR);

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
//   Directed and random stimulus for fifo_param (WIDTH=32, DEPTH=8) with a
//   queue scoreboard. Every output is compared one step after each clock edge.
module tb_fifo_param;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [3:0]       data_count;
    logic             full, empty, almost_full, almost_empty;
    logic             wr_ack, wr_err, rd_ack, rd_err;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_wa, exp_we, exp_ra, exp_re;

    fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .d_in         (d_in),
        .d_out        (d_out),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Applies one cycle of stimulus, predicts the result from the scoreboard,
    // then compares every output #1 after the edge.
    task automatic step(input logic w, input logic r, input logic f,
                        input logic rn, input logic [WIDTH-1:0] din);
        bit full_m, empty_m, rok, wok;
        if (!rn) begin
            q.delete();
            exp_dout = '0;
            {exp_wa, exp_we, exp_ra, exp_re} = 4'b0000;
        end else if (f) begin
            q.delete();
            {exp_wa, exp_we, exp_ra, exp_re} = 4'b0000;
        end else begin
            full_m  = (q.size() == DEPTH);
            empty_m = (q.size() == 0);
            rok = r && !empty_m;
            wok = w && (!full_m || r);
            if (rok) exp_dout = q.pop_front();
            if (wok) q.push_back(din);
            exp_wa = wok;
            exp_we = w && !wok;
            exp_ra = rok;
            exp_re = r && !rok;
        end
        wr_en = w; rd_en = r; flush = f; reset_n = rn; d_in = din;
        @(posedge clk);
        #1;
        chk("d_out",        d_out,        exp_dout);
        chk("data_count",   32'(data_count), 32'(q.size()));
        chk("full",         32'(full),         32'(q.size() == DEPTH));
        chk("empty",        32'(empty),        32'(q.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(q.size() >= DEPTH - 2));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
        chk("wr_ack",       32'(wr_ack),       32'(exp_wa));
        chk("wr_err",       32'(wr_err),       32'(exp_we));
        chk("rd_ack",       32'(rd_ack),       32'(exp_ra));
        chk("rd_err",       32'(rd_err),       32'(exp_re));
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        exp_dout = '0;
        {exp_wa, exp_we, exp_ra, exp_re} = 4'b0000;
        reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;

        // 1: reset then idle
        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 1, '0);

        // 2: fill with 0x11..0x88, then a rejected 9th write
        for (int unsigned i = 1; i <= 8; i++) step(1, 0, 0, 1, 32'(i * 8'h11));
        step(1, 0, 0, 1, 32'h99);
        chk("full_after_fill", 32'(full), 32'h1);

        // 3: drain 9 times; the last read is rejected and d_out holds 0x88
        for (int unsigned i = 0; i < 9; i++) step(0, 1, 0, 1, '0);
        chk("dout_hold_88", d_out, 32'h88);

        // 4: simultaneous read and write while empty, then again with one entry
        step(1, 1, 0, 1, 32'hA5);
        step(1, 1, 0, 1, 32'h5A);
        chk("dout_a5", d_out, 32'hA5);

        // 5: fill up, then read and write together for 10 cycles across the wrap
        while (q.size() < DEPTH) step(1, 0, 0, 1, $urandom);
        for (int unsigned i = 0; i < 10; i++) step(1, 1, 0, 1, 32'h1000 + i);

        // 6: flush with 5 entries held and wr_en asserted
        while (q.size() > 5) step(0, 1, 0, 1, '0);
        held = exp_dout;
        step(1, 0, 1, 1, 32'hDEAD);
        chk("flush_dout_hold", d_out, held);
        // refill, then apply reset and flush together
        for (int unsigned i = 0; i < 5; i++) step(1, 0, 0, 1, 32'h200 + i);
        step(0, 1, 0, 1, '0);
        step(1, 1, 1, 0, 32'hBEEF);
        chk("reset_dout_zero", d_out, 32'h0);
        // the first entry written after reset must be the first entry read back
        step(1, 0, 0, 1, 32'hC0DE);
        step(0, 1, 0, 1, '0);
        chk("post_reset_first", d_out, 32'hC0DE);

        // random traffic with an occasional flush
        for (int unsigned i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0), 1'b1, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
